// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset/increment constants,
// NOP encoding, PC mux select encodings and the fetch queue entry layout.
package cpu_pkg;
   localparam int                 WIDTH    = 32;
   localparam logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000;
   localparam logic [WIDTH-1:0]   PC_INC   = 32'd4;
   localparam logic [WIDTH-1:0]   NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {
      PC_SEQ      = 2'b00,
      PC_BRANCH   = 2'b01,
      PC_JUMP_REG = 2'b10
   } pc_mux_sel_t;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instr;
   } fetch_entry_t;

   // Sequential successor; wraps silently at the top of the address space.
   function automatic logic [WIDTH-1:0] next_seq_pc(input logic [WIDTH-1:0] pc);
      return pc + PC_INC;
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, decode and the
// branch resolution logic. The fetch stage is the master side.
interface fetch_stage_if;
   import cpu_pkg::*;

   // imem: req is a one-cycle pulse, at most one read outstanding, rvalid
   // returns exactly once per request at least one cycle later.
   // decode: instr_valid/dec_ready form a valid/ready pair; the head transfers
   // on a cycle where both are high, and instr/instr_pc are meaningless while
   // instr_valid is low.
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_rvalid;
   logic [WIDTH-1:0] imem_rdata;
   logic             instr_valid;
   logic [WIDTH-1:0] instr;
   logic [WIDTH-1:0] instr_pc;
   logic             dec_ready;
   logic             redirect_en;
   logic [WIDTH-1:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_rvalid, imem_rdata, dec_ready, redirect_en, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_rvalid, imem_rdata, dec_ready, redirect_en, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO organised as head/tail registers so the head
// keeps its last contents once the queue drains or is flushed.
module fetch_queue
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  fetch_entry_t i_data,
   input  logic         i_pop,
   input  logic         i_flush,
   output logic [1:0]   o_count,
   output fetch_entry_t o_head
);
   fetch_entry_t r_head;
   fetch_entry_t r_tail;
   logic [1:0]   r_count;
   logic         w_pop;
   logic         w_push;

   assign w_pop   = i_pop && (r_count != 2'd0);
   assign w_push  = i_push && (w_pop || (r_count != 2'd2));
   assign o_count = r_count;
   assign o_head  = r_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_data;
               else                 r_tail <= i_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd2) r_head <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop: the new word lands behind whatever remains.
               if (r_count == 2'd1) begin
                  r_head <= i_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !i_flush && !w_pop && (r_count == 2'd2)));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues one-at-a-time imem reads,
// buffers responses for decode and handles redirects with stale-response drop.
module fetch_stage
   import cpu_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   fetch_stage_if.master  bus
);
   logic [WIDTH-1:0] r_fetch_pc;
   logic [WIDTH-1:0] r_req_addr;
   logic             r_outstanding;
   logic             r_discard;
   logic             r_post_reset;

   logic             w_issue;
   logic             w_accept;
   logic             w_pop;
   logic [1:0]       w_count;
   fetch_entry_t     w_head;
   fetch_entry_t     w_push_data;

   // Credit rule: a request is only issued with a free slot and nothing in flight,
   // so a response can never find the queue full.
   assign w_issue  = rst_n && !r_outstanding && !r_discard &&
                     (w_count != 2'd2) && !bus.redirect_en;
   assign w_accept = bus.imem_rvalid && r_outstanding && !r_discard && !bus.redirect_en;
   assign w_pop    = (w_count != 2'd0) && bus.dec_ready;

   assign w_push_data.pc    = r_req_addr;
   assign w_push_data.instr = bus.imem_rdata;

   assign bus.imem_req    = w_issue;
   assign bus.imem_addr   = w_issue ? r_fetch_pc : '0;
   assign bus.instr_valid = (w_count != 2'd0);
   assign bus.instr       = w_head.instr;
   assign bus.instr_pc    = w_head.pc;

   fetch_queue u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_accept),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_en),
      .o_count (w_count),
      .o_head  (w_head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_req_addr    <= '0;
         r_outstanding <= 1'b0;
         r_discard     <= 1'b0;
         r_post_reset  <= 1'b1;
      end else begin
         if (w_issue) r_post_reset <= 1'b0;
         if (bus.redirect_en) begin
            r_fetch_pc <= bus.redirect_pc;
            if (r_outstanding) begin
               // A response landing in the redirect cycle is simply dropped here;
               // otherwise the next one to return belongs to the old stream.
               if (bus.imem_rvalid) begin
                  r_outstanding <= 1'b0;
                  r_discard     <= 1'b0;
               end else begin
                  r_discard     <= 1'b1;
               end
            end
         end else begin
            if (r_discard && bus.imem_rvalid) begin
               r_discard     <= 1'b0;
               r_outstanding <= 1'b0;
            end else if (w_accept) begin
               r_outstanding <= 1'b0;
            end
            if (w_issue) begin
               r_outstanding <= 1'b1;
               r_req_addr    <= r_fetch_pc;
               r_fetch_pc    <= next_seq_pc(r_fetch_pc);
            end
         end
      end
   end

   // Unsolicited read data is ignored; a leftover from before reset may still
   // show up before the first new request goes out.
   a_no_unsolicited_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.imem_rvalid && !r_outstanding && !r_post_reset));
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model plus an expected
// instruction-stream scoreboard, driven by directed and random scenarios.
module tb_fetch_stage;
   import cpu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fetch_stage_if bus();

   fetch_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- bench state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc;
   logic [31:0] key;
   bit          mem_pending;
   logic [31:0] mem_addr;
   int          mem_wait;
   int          lat_min, lat_max;
   bit          stale_now;
   bit          prev_redir;
   logic [31:0] exp_q[$];
   logic [31:0] exp_next;
   logic [31:0] exp_req;
   logic [31:0] req_log[$];
   int          req_cyc[$];
   logic [31:0] pop_log[$];
   int          first_valid_cyc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ key;
   endfunction

   task automatic restart_stream(input logic [31:0] pc);
      exp_q.delete();
      exp_next = pc;
      exp_req  = pc;
   endtask

   task automatic clear_logs();
      req_log.delete();
      req_cyc.delete();
      pop_log.delete();
   endtask

   // ---------------- driver + scoreboard, one clock per call ----------------
   task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
      bit          resp;
      logic [31:0] want;
      bus.dec_ready   = rdy;
      bus.redirect_en = redir;
      bus.redirect_pc = rpc;
      resp            = mem_pending && (mem_wait == 0);
      bus.imem_rvalid = resp || stale_now;
      bus.imem_rdata  = resp ? mem_word(mem_addr) : ~mem_word(32'hDEAD_0000);
      stale_now       = 1'b0;
      if (resp) mem_pending = 1'b0;
      if (prev_redir) begin
         n_cmp++;
         if (bus.instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_valid: got instr_valid=%b want 0 (cycle %0d)", bus.instr_valid, cyc);
         end
      end
      #1;
      if (bus.imem_req === 1'b1) begin
         req_log.push_back(bus.imem_addr);
         req_cyc.push_back(cyc);
         n_cmp++;
         if (bus.imem_addr !== exp_req) begin
            n_bad++;
            $display("FAIL req_addr: got %h want %h (cycle %0d)", bus.imem_addr, exp_req, cyc);
         end
         n_cmp++;
         if (mem_pending || resp) begin
            n_bad++;
            $display("FAIL one_outstanding: got second request at %h want none (cycle %0d)", bus.imem_addr, cyc);
         end
         exp_req     = exp_req + 32'd4;
         mem_pending = 1'b1;
         mem_addr    = bus.imem_addr;
         mem_wait    = $urandom_range(lat_max, lat_min);
      end
      if (bus.instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.instr_valid === 1'b1 && rdy && !redir) begin
         while (exp_q.size() < 4) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
         end
         want = exp_q.pop_front();
         pop_log.push_back(bus.instr_pc);
         n_cmp++;
         if (bus.instr_pc !== want) begin
            n_bad++;
            $display("FAIL instr_pc: got %h want %h (cycle %0d)", bus.instr_pc, want, cyc);
         end
         n_cmp++;
         if (bus.instr !== mem_word(want)) begin
            n_bad++;
            $display("FAIL instr_data: got %h want %h (cycle %0d)", bus.instr, mem_word(want), cyc);
         end
      end
      if (redir) begin
         restart_stream(rpc);
         n_cmp++;
         if (bus.imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL redirect_no_req: got imem_req=%b want 0 (cycle %0d)", bus.imem_req, cyc);
         end
      end
      prev_redir = redir;
      @(posedge clk);
      #1;
      cyc++;
      if (mem_pending && mem_wait > 0) mem_wait--;
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.dec_ready   = 1'b0;
      bus.redirect_en = 1'b0;
      bus.redirect_pc = '0;
      mem_pending     = 1'b0;
      stale_now       = 1'b0;
      prev_redir      = 1'b0;
      restart_stream(RESET_PC);
      clear_logs();
      first_valid_cyc = -1;
      cyc             = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(posedge clk);
      #1;
      rst_n           = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.dec_ready   = 1'b1;
      bus.redirect_en = 1'b0;
      bus.redirect_pc = '0;
      #2;
      n_cmp++; if (bus.imem_req !== 1'b0)   begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
      n_cmp++; if (bus.imem_addr !== '0)    begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
      n_cmp++; if (bus.instr !== '0)        begin n_bad++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
      n_cmp++; if (bus.instr_pc !== '0)     begin n_bad++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_a[3];
      logic [31:0] got;
      exp_a = '{32'h0, 32'h4, 32'h8};
      lat_min = 1; lat_max = 1;
      do_reset();
      repeat (12) cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         got = (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
         n_cmp++;
         if (got !== exp_a[i]) begin n_bad++; $display("FAIL seq_addr%0d: got %h want %h", i, got, exp_a[i]); end
      end
      n_cmp++;
      if (req_cyc.size() == 0 || first_valid_cyc != req_cyc[0] + 2) begin
         n_bad++;
         $display("FAIL seq_latency: got first valid at cycle %0d want first req + 2", first_valid_cyc);
      end
      got = (pop_log.size() > 0) ? pop_log[0] : 32'hxxxx_xxxx;
      n_cmp++;
      if (got !== RESET_PC) begin n_bad++; $display("FAIL seq_first_pc: got %h want %h", got, RESET_PC); end
   endtask

   task automatic test_stall();
      logic [31:0] got;
      lat_min = 1; lat_max = 1;
      do_reset();
      repeat (10) cycle(1'b0, 1'b0, '0);
      n_cmp++;
      if (req_log.size() != 2) begin n_bad++; $display("FAIL stall_req_count: got %0d want 2", req_log.size()); end
      n_cmp++;
      if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_full: got valid=%b req=%b want valid=1 req=0", bus.instr_valid, bus.imem_req);
      end
      clear_logs();
      repeat (8) cycle(1'b1, 1'b0, '0);
      got = (pop_log.size() > 0) ? pop_log[0] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL stall_drain0: got %h want 0", got); end
      got = (pop_log.size() > 1) ? pop_log[1] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== 32'h4) begin n_bad++; $display("FAIL stall_drain1: got %h want 4", got); end
      got = (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== 32'h8) begin n_bad++; $display("FAIL stall_resume: got %h want 8", got); end
   endtask

   task automatic test_redirect_inflight();
      logic [31:0] got;
      int          n;
      lat_min = 3; lat_max = 3;
      do_reset();
      n = 0;
      while (!(req_log.size() > 0 && req_log[req_log.size()-1] == 32'h8 && mem_pending && mem_wait >= 1) && n < 40) begin
         cycle(1'b1, 1'b0, '0);
         n++;
      end
      n_cmp++;
      if (n >= 40) begin n_bad++; $display("FAIL inflight_setup: got timeout want request to 8 in flight"); end
      cycle(1'b1, 1'b1, 32'h100);
      clear_logs();
      repeat (15) cycle(1'b1, 1'b0, '0);
      got = (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== 32'h100) begin n_bad++; $display("FAIL inflight_req: got %h want 100", got); end
      got = (pop_log.size() > 0) ? pop_log[0] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== 32'h100) begin n_bad++; $display("FAIL inflight_pc: got %h want 100", got); end
   endtask

   task automatic test_redirect_collide();
      logic [31:0] got;
      int          n;
      lat_min = 3; lat_max = 3;
      do_reset();
      n = 0;
      while (!(bus.instr_valid === 1'b1 && mem_pending && mem_wait == 0) && n < 40) begin
         cycle(1'b0, 1'b0, '0);
         n++;
      end
      n_cmp++;
      if (n >= 40) begin n_bad++; $display("FAIL collide_setup: got timeout want response with valid head"); end
      cycle(1'b1, 1'b1, 32'h200);
      clear_logs();
      repeat (15) cycle(1'b1, 1'b0, '0);
      got = (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== 32'h200) begin n_bad++; $display("FAIL collide_req: got %h want 200", got); end
      got = (pop_log.size() > 0) ? pop_log[0] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== 32'h200) begin n_bad++; $display("FAIL collide_pc: got %h want 200", got); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a[3];
      logic [31:0] got;
      exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      lat_min = 1; lat_max = 1;
      do_reset();
      cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
      clear_logs();
      repeat (10) cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         got = (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
         n_cmp++;
         if (got !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, got, exp_a[i]); end
      end
      got = (pop_log.size() > 2) ? pop_log[2] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL wrap_pc: got %h want 0", got); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] got;
      int          n;
      lat_min = 3; lat_max = 3;
      do_reset();
      n = 0;
      while (!(req_log.size() >= 2 && mem_pending && mem_wait >= 2) && n < 40) begin
         cycle(1'b1, 1'b0, '0);
         n++;
      end
      n_cmp++;
      if (n >= 40) begin n_bad++; $display("FAIL midreset_setup: got timeout want request in flight"); end
      do_reset();
      stale_now = 1'b1;
      repeat (12) cycle(1'b1, 1'b0, '0);
      got = (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== RESET_PC) begin n_bad++; $display("FAIL midreset_req: got %h want %h", got, RESET_PC); end
      got = (pop_log.size() > 0) ? pop_log[0] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== RESET_PC) begin n_bad++; $display("FAIL midreset_pc: got %h want %h", got, RESET_PC); end
   endtask

   task automatic test_random();
      bit          rdy, redir;
      logic [31:0] rpc;
      lat_min = 1; lat_max = 4;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 29) == 0);
         rpc   = $urandom & 32'hFFFF_FFFC;
         cycle(rdy, redir, rpc);
      end
      n_cmp++;
      if (pop_log.size() < 200) begin
         n_bad++;
         $display("FAIL random_progress: got %0d instructions want at least 200", pop_log.size());
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      key = $urandom;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_inflight();
      test_redirect_collide();
      test_wrap();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
